// File: rtl/control_unit_if.sv
// control_unit_if
// Groups the memory-side and datapath-side signals of the control unit.
//   data_in  : memory read data (opcode in FETCH, operand afterwards)
//   p        : processor status register (N=7, V=6, Z=1, C=0)
//   controls : 37-bit control word driven to the datapath
// Modports:
//   master : the environment/datapath side, drives data_in and p
//   slave  : the control unit itself, drives controls
interface control_unit_if;
    logic [7:0]  data_in;
    logic [7:0]  p;
    logic [36:0] controls;

    modport master (output data_in, output p, input controls);
    modport slave  (input data_in, input p, output controls);
endinterface

// File: rtl/control_unit.sv
// control_unit
// Microsequenced 6502 control unit. Latches the opcode in FETCH, walks an
// 8-bit state register through the cycles of that instruction and drives a
// combinational 37-bit control word to the datapath.
// Ports:
//   ph1   : clock, all state updates on its rising edge
//   reset : asynchronous, active-high reset
//   ph2   : present only to match the CPU top port list; ignored
//   bus   : control_unit_if.slave (data_in, p in; controls out)
module control_unit (
    input  logic               ph1,
    input  logic               reset,
    input  logic               ph2,
    control_unit_if.slave      bus
);

    typedef enum logic [7:0] {
        S_RESET    = 8'd0,
        S_FETCH    = 8'd1,
        S_IMM      = 8'd2,
        S_ZP_ADDR  = 8'd3,
        S_ZP_EXEC  = 8'd4,
        S_ABS_LO   = 8'd5,
        S_ABS_HI   = 8'd6,
        S_ABS_EXEC = 8'd7,
        S_BRANCH   = 8'd8,
        S_JMP_LO   = 8'd9,
        S_JMP_HI   = 8'd10,
        S_NOP      = 8'd11
    } state_t;

    // The register is a plain byte so any value (including illegal ones)
    // can be held and recovered from.
    logic [7:0] state;
    state_t     state_nxt;
    logic [7:0] ir;

    logic       pc_inc, pc_load_lo, pc_load_hi, ir_load, mem_write;
    logic [1:0] addr_sel;
    logic       adl_load, adh_load;
    logic [3:0] alu_op;
    logic [1:0] alu_a_sel, alu_b_sel;
    logic [3:0] reg_write;
    logic [7:0] p_write_mask;
    logic       carry_sel, carry_const, sp_inc, sp_dec, branch_taken;
    logic [1:0] data_out_sel;
    logic       sync;
    logic       execute;
    logic       flag;

    // ph2 and the bits of p / ir that no state looks at.
    logic unused_bits;
    assign unused_bits = ^{ph2, bus.p[5:2], ir[4:0]};

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
            ir    <= 8'hEA;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH)
                ir <= bus.data_in;
        end
    end

    always_comb begin
        state_nxt    = S_FETCH;
        pc_inc       = 1'b0;
        pc_load_lo   = 1'b0;
        pc_load_hi   = 1'b0;
        ir_load      = 1'b0;
        mem_write    = 1'b0;
        addr_sel     = 2'd0;
        adl_load     = 1'b0;
        adh_load     = 1'b0;
        alu_op       = 4'd0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 2'd0;
        reg_write    = 4'd0;
        p_write_mask = 8'd0;
        carry_sel    = 1'b0;
        carry_const  = 1'b0;
        sp_inc       = 1'b0;
        sp_dec       = 1'b0;
        branch_taken = 1'b0;
        data_out_sel = 2'd0;
        sync         = 1'b0;
        execute      = 1'b0;
        flag         = 1'b0;

        case (state)
            S_RESET: state_nxt = S_FETCH;
            S_FETCH: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                sync    = 1'b1;
                if (bus.data_in[1:0] == 2'b01) begin
                    case (bus.data_in[4:2])
                        // 0x89 would be STA #imm, which does not exist
                        3'b010:  state_nxt = (bus.data_in == 8'h89) ? S_NOP : S_IMM;
                        3'b001:  state_nxt = S_ZP_ADDR;
                        3'b011:  state_nxt = S_ABS_LO;
                        default: state_nxt = S_NOP;
                    endcase
                end else if (bus.data_in[4:0] == 5'b10000) begin
                    state_nxt = S_BRANCH;
                end else if (bus.data_in == 8'h4C) begin
                    state_nxt = S_JMP_LO;
                end else begin
                    state_nxt = S_NOP;
                end
            end
            S_IMM: begin
                pc_inc  = 1'b1;
                execute = 1'b1;
            end
            S_ZP_ADDR: begin
                adl_load  = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = S_ZP_EXEC;
            end
            S_ZP_EXEC: begin
                addr_sel = 2'd2;
                execute  = 1'b1;
            end
            S_ABS_LO: begin
                adl_load  = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = S_ABS_HI;
            end
            S_ABS_HI: begin
                adh_load  = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = S_ABS_EXEC;
            end
            S_ABS_EXEC: begin
                addr_sel = 2'd1;
                execute  = 1'b1;
            end
            S_BRANCH: begin
                pc_inc = 1'b1;
                case (ir[7:6])
                    2'b00:   flag = bus.p[7];
                    2'b01:   flag = bus.p[6];
                    2'b10:   flag = bus.p[0];
                    default: flag = bus.p[1];
                endcase
                branch_taken = (flag == ir[5]);
            end
            S_JMP_LO: begin
                adl_load  = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = S_JMP_HI;
            end
            S_JMP_HI: begin
                pc_load_lo = 1'b1;
                pc_load_hi = 1'b1;
            end
            S_NOP:   state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase

        // Shared ALU-group execute cycle for IMM / ZP / ABS.
        if (execute) begin
            alu_op = {1'b0, ir[7:5]};
            case (ir[7:5])
                3'b011, 3'b111: begin            // ADC, SBC
                    carry_sel    = 1'b1;
                    reg_write    = 4'b0001;
                    p_write_mask = 8'hC3;
                end
                3'b110: begin                    // CMP: compare with borrow-in = 1
                    carry_const  = 1'b1;
                    p_write_mask = 8'h83;
                end
                3'b100: begin                    // STA: A passes through ALU (B = 0)
                    mem_write    = 1'b1;
                    alu_b_sel    = 2'd1;
                end
                default: begin                   // ORA, AND, EOR, LDA
                    reg_write    = 4'b0001;
                    p_write_mask = 8'h82;
                end
            endcase
        end
    end

    assign bus.controls = {pc_inc, pc_load_lo, pc_load_hi, ir_load, mem_write,
                           addr_sel, adl_load, adh_load, alu_op, alu_a_sel,
                           alu_b_sel, reg_write, p_write_mask, carry_sel,
                           carry_const, sp_inc, sp_dec, branch_taken,
                           data_out_sel, sync};

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic ph1 = 1'b0;
    logic ph2 = 1'b0;
    logic reset;

    control_unit_if bus_if ();

    control_unit dut (
        .ph1   (ph1),
        .reset (reset),
        .ph2   (ph2),
        .bus   (bus_if.slave)
    );

    always #5 ph1 = ~ph1;
    always #5 ph2 = ~ph1;

    localparam logic [36:0] PC_INC  = 37'd1 << 36;
    localparam logic [36:0] PC_LO   = 37'd1 << 35;
    localparam logic [36:0] PC_HI   = 37'd1 << 34;
    localparam logic [36:0] IR_LD   = 37'd1 << 33;
    localparam logic [36:0] MEM_WR  = 37'd1 << 32;
    localparam logic [36:0] A_ABS   = 37'd1 << 30;
    localparam logic [36:0] A_ZP    = 37'd2 << 30;
    localparam logic [36:0] ADL     = 37'd1 << 29;
    localparam logic [36:0] ADH     = 37'd1 << 28;
    localparam logic [36:0] B_ZERO  = 37'd1 << 20;
    localparam logic [36:0] REG_A   = 37'd1 << 16;
    localparam logic [36:0] CSEL    = 37'd1 << 7;
    localparam logic [36:0] CCONST  = 37'd1 << 6;
    localparam logic [36:0] BR      = 37'd1 << 3;
    localparam logic [36:0] SYNC    = 37'd1;
    localparam logic [36:0] FETCH_W = PC_INC | IR_LD | SYNC;

    typedef struct {
        string       tag;
        logic [7:0]  st;
        logic [36:0] ctl;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk_ctl(input string tag, input logic [36:0] exp);
        checks++;
        assert (bus_if.controls === exp) else begin
            errors++;
            $error("FAIL %s controls got %h want %h", tag, bus_if.controls, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [7:0] exp);
        checks++;
        assert (dut.state === exp) else begin
            errors++;
            $error("FAIL %s state got %h want %h", tag, dut.state, exp);
        end
    endtask

    // One clock of stimulus: after the edge drive inputs and queue the
    // expected state/control word, then compare on the falling edge.
    task automatic step(input string tag, input logic [7:0] d, input logic [7:0] pv,
                        input logic [7:0] es, input logic [36:0] ec);
        exp_t e;
        @(posedge ph1);
        #1;
        bus_if.data_in = d;
        bus_if.p       = pv;
        sb.push_back('{tag, es, ec});
        @(negedge ph1);
        e = sb.pop_front();
        chk_st(e.tag, e.st);
        chk_ctl(e.tag, e.ctl);
    endtask

    initial begin
        reset = 1'b1;
        bus_if.data_in = 8'h00;
        bus_if.p       = 8'h00;
        #100;
        chk_ctl("rst_ctl", 37'h0);
        chk_st("rst_state", 8'd0);
        checks++;
        assert (dut.ir === 8'hEA) else begin
            errors++;
            $error("FAIL rst_ir got %h want ea", dut.ir);
        end
        reset = 1'b0;

        // LDA #imm
        step("lda_fetch", 8'hA9, 8'h00, 8'd1, FETCH_W);
        step("lda_imm",   8'h42, 8'h00, 8'd2, PC_INC | (37'd5 << 24) | REG_A | (37'h82 << 8));
        // STA abs
        step("sta_fetch", 8'h8D, 8'h00, 8'd1, FETCH_W);
        step("sta_lo",    8'h00, 8'h00, 8'd5, ADL | PC_INC);
        step("sta_hi",    8'h02, 8'h00, 8'd6, ADH | PC_INC);
        step("sta_exec",  8'h00, 8'h00, 8'd7, A_ABS | MEM_WR | (37'd4 << 24) | B_ZERO);
        // ADC zp
        step("adc_fetch", 8'h65, 8'h01, 8'd1, FETCH_W);
        step("adc_addr",  8'h10, 8'h01, 8'd3, ADL | PC_INC);
        step("adc_exec",  8'h33, 8'h01, 8'd4, A_ZP | (37'd3 << 24) | CSEL | REG_A | (37'hC3 << 8));
        // CMP #imm
        step("cmp_fetch", 8'hC9, 8'h00, 8'd1, FETCH_W);
        step("cmp_imm",   8'h05, 8'h00, 8'd2, PC_INC | (37'd6 << 24) | CCONST | (37'h83 << 8));
        // BEQ taken / not taken, BMI taken
        step("beq_fetch", 8'hF0, 8'h02, 8'd1, FETCH_W);
        step("beq_take",  8'h04, 8'h02, 8'd8, PC_INC | BR);
        step("beq_fetch2",8'hF0, 8'h00, 8'd1, FETCH_W);
        step("beq_skip",  8'h04, 8'h00, 8'd8, PC_INC);
        step("bmi_fetch", 8'h30, 8'h80, 8'd1, FETCH_W);
        step("bmi_take",  8'hFE, 8'h80, 8'd8, PC_INC | BR);
        // 0x89 is carved out of the immediate group
        step("x89_fetch", 8'h89, 8'h00, 8'd1, FETCH_W);
        step("x89_nop",   8'h00, 8'h00, 8'd11, 37'h0);
        // JMP abs
        step("jmp_fetch", 8'h4C, 8'h00, 8'd1, FETCH_W);
        step("jmp_lo",    8'h00, 8'h00, 8'd9, ADL | PC_INC);
        step("jmp_hi",    8'h80, 8'h00, 8'd10, PC_LO | PC_HI);
        // Unsupported opcode
        step("x02_fetch", 8'h02, 8'h00, 8'd1, FETCH_W);
        step("x02_nop",   8'h00, 8'h00, 8'd11, 37'h0);

        // Illegal state recovery
        #1;
        force dut.state = 8'h55;
        #1;
        chk_ctl("illegal_ctl", 37'h0);
        release dut.state;
        step("illegal_next", 8'hA9, 8'h00, 8'd1, FETCH_W);
        step("lda_imm2",     8'h01, 8'h00, 8'd2, PC_INC | (37'd5 << 24) | REG_A | (37'h82 << 8));

        // Reset mid STA abs: no write ever reaches ABS_EXEC
        step("sta2_fetch", 8'h8D, 8'h00, 8'd1, FETCH_W);
        step("sta2_lo",    8'h00, 8'h00, 8'd5, ADL | PC_INC);
        step("sta2_hi",    8'h02, 8'h00, 8'd6, ADH | PC_INC);
        #2;
        reset = 1'b1;
        #1;
        chk_ctl("midrst_ctl", 37'h0);
        chk_st("midrst_state", 8'd0);
        @(posedge ph1);
        #1;
        chk_ctl("midrst_hold", 37'h0);
        #2;
        reset = 1'b0;
        step("post_fetch", 8'hEA, 8'h00, 8'd1, FETCH_W);
        step("post_nop",   8'h00, 8'h00, 8'd11, 37'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Microsequenced control unit of the 6502 datapath. It latches each opcode, steps an 8-bit state register through the cycles of that instruction, and drives a 37-bit control word (`controls`) that steers PC, address mux, ALU, register file, stack pointer and status-flag writes. It sits between the memory data bus and the datapath, and consumes the status register `p` for branch decisions.

## Interface

- No parameters.
- `ph1`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ph2`  in  1  unused by this block; kept so the port list matches the CPU top. Must not affect behaviour.
- `data_in`  in  8  memory read data: opcode in FETCH, operand in later states.
- `p`  in  8  status register: N=p[7], V=p[6], Z=p[1], C=p[0].
- `controls`  out  37  control word, bit fields below.

Control word fields; a field is 0 unless stated:

- [36] pc_inc
- [35] pc_load_lo
- [34] pc_load_hi
- [33] ir_load
- [32] mem_write
- [31:30] addr_sel: 0 = PC, 1 = {ADH,ADL}, 2 = {00,ADL}, 3 = {01,SP}
- [29] adl_load
- [28] adh_load
- [27:24] alu_op
- [23:22] alu_a_sel: 0 = A, 1 = X, 2 = Y, 3 = zero
- [21:20] alu_b_sel: 0 = data_in, 1 = zero
- [19:16] reg_write, one-hot: A, X, Y, SP
- [15:8] p_write_mask, per P bit
- [7] carry_sel: 0 = constant, 1 = P.C
- [6] carry_const
- [5] sp_inc
- [4] sp_dec
- [3] branch_taken
- [2:1] data_out_sel: 0 = ALU
- [0] sync

## Operation

Internal registers:
- `state`[7:0]
- `ir`[7:0], loaded from `data_in` in FETCH.

States and transitions:
- 0 RESET → 1.
- 1 FETCH: addr_sel=0, ir_load, pc_inc, sync. Next state from `data_in`:
  - ALU group (opcode[1:0]=01) with bbb=010 (immediate) → 2. Opcode 0x89 is excepted → 11.
  - ALU group with bbb=001 (zero page) → 3.
  - ALU group with bbb=011 (absolute) → 5.
  - Branch (opcode[4:0]=10000) → 8.
  - 0x4C (JMP abs) → 9.
  - Anything else → 11.
- 2 IMM: pc_inc; execute ALU op with B = data_in → 1.
- 3 ZP_ADDR: adl_load, pc_inc → 4.
- 4 ZP_EXEC: addr_sel=2; execute → 1.
- 5 ABS_LO: adl_load, pc_inc → 6.
- 6 ABS_HI: adh_load, pc_inc → 7.
- 7 ABS_EXEC: addr_sel=1; execute → 1.
- 8 BRANCH_OFF: pc_inc. branch_taken = (P[flag] == ir[5]), where ir[7:6] selects the flag: 00 N, 01 V, 10 C, 11 Z → 1.
- 9 JMP_LO: adl_load, pc_inc → 10.
- 10 JMP_HI: pc_load_lo, pc_load_hi (datapath takes low byte from ADL) → 1.
- 11 NOP: no fields set → 1.
- Any other state value → 1 (illegal-state recovery), with controls all zero in that cycle.

Execute, aaa = ir[7:5], alu_op = {0,aaa}:
- ORA/AND/EOR/LDA (000/001/010/101): reg_write A; p mask N,Z.
- ADC (011): carry_sel=1; reg_write A; mask N,V,Z,C.
- SBC (111): carry_sel=1; reg_write A; mask N,V,Z,C.
- CMP (110): carry_const=1, carry_sel=0; no reg_write; mask N,Z,C.
- STA (100): mem_write; alu_b_sel=1; data_out_sel=0.

`controls` is purely combinational from `state`, `ir`, `data_in` and `p`.

## Timing

- `reset` high, asynchronously: state=0, ir=0xEA. While in RESET, controls = 37'h0.
- First rising `ph1` after reset deasserts: state → 1.
- Cycle counts:
  - IMM: 2
  - ZP: 3
  - ABS: 4
  - branch: 2
  - JMP: 3
  - NOP/unsupported: 2
- Reset asserted mid-instruction aborts it immediately; no further mem_write occurs.
- `data_in` and `p` are sampled combinationally in the same cycle they are used. No handshake.

## Test plan

- Reset held 100 ns: `controls` == 0, `state` == 0. After release, the next edge gives state 1 and sync=1.
- FETCH with data_in=0xA9, then 0x42: state sequence 1→2→1. In state 2: reg_write=0001 (A), p_write_mask bits 7 and 1 set, pc_inc=1.
- data_in=0x8D (STA abs): states 1→5→6→7→1. In state 7: mem_write=1, addr_sel=1, reg_write=0.
- Opcode 0xF0 (BEQ) with p=0x02: state 8 has branch_taken=1. With p=0x00: branch_taken=0.
- Opcode 0x4C: states 1→9→10→1. State 10 has pc_load_lo=pc_load_hi=1.
- Unsupported opcode 0x01-free value 0x02: goes 1→11→1. Forcing state to 0x55 yields controls=0, then state 1 on the next edge.
